// File: rtl/prog_sequencer_if.sv
// Host command / CPU-side bus for the program sequencer.
// master = host + CPU side, slave = sequencer.
interface prog_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int CYC_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_data;
   logic [CYC_W-1:0]  run_limit;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_data;
   logic              cpu_en;
   logic              busy;
   logic              done;
   logic [CYC_W-1:0]  cyc_count;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, run_limit, cpu_addr,
      input  cmd_ready, cpu_data, cpu_en, busy, done, cyc_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, run_limit, cpu_addr,
      output cmd_ready, cpu_data, cpu_en, busy, done, cyc_count
   );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller and 1-bit program store for the 1-bit-instruction CPU.
// Host issues LOAD / RUN / STEP / HALT; the block gates the CPU clock-enable
// and counts enabled cycles (saturating).
module prog_sequencer #(
   parameter int ADDR_W = 4,
   parameter int CYC_W  = 8
) (
   input logic             clk,
   input logic             rst,
   prog_sequencer_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

   localparam logic [1:0]       OP_LOAD = 2'b00;
   localparam logic [1:0]       OP_RUN  = 2'b01;
   localparam logic [1:0]       OP_STEP = 2'b10;
   localparam logic [1:0]       OP_HALT = 2'b11;
   localparam int               DEPTH   = 1 << ADDR_W;
   localparam logic [CYC_W-1:0] CYC_MAX = '1;
   localparam logic [CYC_W:0]   ONE     = 1;

   state_t            r_state, w_next;
   logic [DEPTH-1:0]  r_mem;
   logic [CYC_W-1:0]  r_limit;
   logic [CYC_W-1:0]  r_cyc;
   logic              r_done;
   logic              w_ready;
   logic              w_accept;
   logic              w_start;
   logic              w_limit_hit;
   logic [CYC_W:0]    w_cyc_inc;

   // HALT is the only command that may interrupt a RUN; STEP never yields
   assign w_ready  = (r_state == S_IDLE) | ((r_state == S_RUN) & (bus.cmd_op == OP_HALT));
   assign w_accept = bus.cmd_valid & w_ready;
   assign w_start  = (r_state == S_IDLE) & w_accept &
                     ((bus.cmd_op == OP_RUN) | (bus.cmd_op == OP_STEP));

   // one extra bit so a limit of all-ones is still reachable before wrap
   assign w_cyc_inc   = {1'b0, r_cyc} + ONE;
   assign w_limit_hit = (r_limit != '0) && (w_cyc_inc == {1'b0, r_limit});

   // next-state decode; limit and HALT in the same cycle fold into one exit
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && bus.cmd_op == OP_RUN)       w_next = S_RUN;
            else if (w_accept && bus.cmd_op == OP_STEP) w_next = S_STEP;
         end
         S_RUN:   if (w_limit_hit || w_accept) w_next = S_IDLE;
         S_STEP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state, registered done pulse, run limit and saturating cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_limit <= '0;
         r_cyc   <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state != S_IDLE) && (w_next == S_IDLE);
         if (w_start) begin
            r_cyc <= '0;
            if (bus.cmd_op == OP_RUN) r_limit <= bus.run_limit;
         end else if (r_state != S_IDLE && r_cyc != CYC_MAX) begin
            r_cyc <= w_cyc_inc[CYC_W-1:0];
         end
      end
   end

   // program RAM: writable only from IDLE, so it is stable while the CPU runs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '0;
      end else if (r_state == S_IDLE && w_accept && bus.cmd_op == OP_LOAD) begin
         r_mem[bus.cmd_addr] <= bus.cmd_data;
      end
   end

   assign bus.cmd_ready = w_ready;
   assign bus.cpu_data  = r_mem[bus.cpu_addr];
   assign bus.cpu_en    = (r_state != S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
   assign bus.cyc_count = r_cyc;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: table of LOAD/readback vectors plus
// hand-written sequences for RUN limit, unlimited RUN + HALT, STEP and reset.
module tb_prog_sequencer;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   prog_sequencer_if #(.ADDR_W(4), .CYC_W(8)) bus ();

   prog_sequencer #(.ADDR_W(4), .CYC_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [3:0] addr;
      logic       data;
      logic [3:0] cpu_addr;
      logic       exp_ready;
      logic       exp_data;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // present a command at posedge+1, it is accepted on the following edge
   task automatic send(input logic [1:0] op, input logic [3:0] addr,
                       input logic data, input logic [7:0] limit);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_data  = data;
      bus.run_limit = limit;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int en_cnt, done_cnt, cyc_at_done;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_addr  = '0;
      bus.cmd_data  = 1'b0;
      bus.run_limit = '0;
      bus.cpu_addr  = '0;

      //          valid op       addr  d     cpu   rdy   data
      vecs[0]  = '{1'b1, OP_LOAD, 4'd3,  1'b1, 4'd3,  1'b1, 1'b0};
      vecs[1]  = '{1'b1, OP_LOAD, 4'd5,  1'b1, 4'd3,  1'b1, 1'b1};
      vecs[2]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd5,  1'b1, 1'b1};
      vecs[3]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd4,  1'b1, 1'b0};
      vecs[4]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd2,  1'b1, 1'b0};
      vecs[5]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd6,  1'b1, 1'b0};
      vecs[6]  = '{1'b1, OP_HALT, 4'd0,  1'b0, 4'd3,  1'b1, 1'b1};
      vecs[7]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0};
      vecs[8]  = '{1'b1, OP_LOAD, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd15, 1'b1, 1'b1};
      vecs[10] = '{1'b1, OP_LOAD, 4'd15, 1'b0, 4'd15, 1'b1, 1'b1};
      vecs[11] = '{1'b0, OP_LOAD, 4'd0,  1'b0, 4'd15, 1'b1, 1'b0};

      // reset state
      #3;
      chk("rst_cpu_en", bus.cpu_en, 0);
      chk("rst_busy",   bus.busy, 0);
      chk("rst_done",   bus.done, 0);
      chk("rst_cyc",    bus.cyc_count, 0);
      chk("rst_ready",  bus.cmd_ready, 1);
      #9 rst = 1'b0;

      // LOAD and combinational readback vectors
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         bus.cmd_valid = vecs[i].valid;
         bus.cmd_op    = vecs[i].op;
         bus.cmd_addr  = vecs[i].addr;
         bus.cmd_data  = vecs[i].data;
         bus.cpu_addr  = vecs[i].cpu_addr;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), bus.cmd_ready, vecs[i].exp_ready);
         chk($sformatf("vec%0d_data", i),  bus.cpu_data,  vecs[i].exp_data);
         chk($sformatf("vec%0d_busy", i),  bus.busy, 0);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;

      // RUN limit 5, LOAD/STEP refused while running
      send(OP_RUN, 4'd0, 1'b0, 8'd5);
      en_cnt = 0; done_cnt = 0; cyc_at_done = -1;
      for (int i = 0; i < 12; i++) begin
         bus.cmd_valid = (i < 2);
         bus.cmd_op    = (i == 0) ? OP_LOAD : OP_STEP;
         bus.cmd_addr  = 4'd7;
         bus.cmd_data  = 1'b1;
         @(negedge clk);
         if (i < 2) chk($sformatf("run5_ready%0d", i), bus.cmd_ready, 0);
         en_cnt += int'(bus.cpu_en);
         if (bus.done) begin
            done_cnt++;
            cyc_at_done = int'(bus.cyc_count);
         end
         @(posedge clk); #1;
      end
      chk("run5_en_cycles", en_cnt, 5);
      chk("run5_done_pulses", done_cnt, 1);
      chk("run5_cyc_count", cyc_at_done, 5);
      bus.cpu_addr = 4'd7;
      #1 chk("run5_no_load", bus.cpu_data, 0);

      // STEP, then HALT held from the next cycle
      send(OP_STEP, 4'd0, 1'b0, 8'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_HALT;
      @(negedge clk);
      chk("step_en", bus.cpu_en, 1);
      chk("step_ready_halt", bus.cmd_ready, 0);
      @(negedge clk);
      chk("step_en_off", bus.cpu_en, 0);
      chk("step_done", bus.done, 1);
      chk("step_cyc", bus.cyc_count, 1);
      chk("step_halt_ready_idle", bus.cmd_ready, 1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         done_cnt += int'(bus.done);
      end
      chk("step_halt_no_done", done_cnt, 0);
      chk("step_halt_busy", bus.busy, 0);
      chk("step_cyc_hold", bus.cyc_count, 1);

      // RUN limit 3 with HALT in the 3rd enabled cycle
      send(OP_RUN, 4'd0, 1'b0, 8'd3);
      en_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         bus.cmd_valid = (i == 2);
         bus.cmd_op    = OP_HALT;
         @(negedge clk);
         if (i == 2) chk("run3_halt_ready", bus.cmd_ready, 1);
         en_cnt   += int'(bus.cpu_en);
         done_cnt += int'(bus.done);
         @(posedge clk); #1;
      end
      chk("run3_en_cycles", en_cnt, 3);
      chk("run3_done_pulses", done_cnt, 1);
      chk("run3_cyc", bus.cyc_count, 3);

      // unlimited RUN past saturation, then HALT
      send(OP_RUN, 4'd0, 1'b0, 8'd0);
      repeat (300) @(negedge clk);
      chk("run0_cyc_sat", bus.cyc_count, 255);
      chk("run0_en", bus.cpu_en, 1);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_HALT;
      #1 chk("run0_halt_ready", bus.cmd_ready, 1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("run0_en_off", bus.cpu_en, 0);
      chk("run0_busy_off", bus.busy, 0);
      chk("run0_done", bus.done, 1);
      chk("run0_cyc_hold", bus.cyc_count, 255);
      @(negedge clk);
      chk("run0_done_once", bus.done, 0);

      // async reset in the middle of a RUN clears everything at once
      send(OP_RUN, 4'd0, 1'b0, 8'd0);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", bus.busy, 1);
      bus.cpu_addr = 4'd3;
      #1 chk("pre_rst_mem3", bus.cpu_data, 1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_cpu_en", bus.cpu_en, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_cyc", bus.cyc_count, 0);
      chk("midrst_done", bus.done, 0);
      for (int a = 0; a < 16; a++) begin
         bus.cpu_addr = 4'(a);
         #1 chk($sformatf("midrst_mem%0d", a), bus.cpu_data, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // hard time bound so the bench always terminates
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
